// File: rtl/etapa_busqueda.sv
// MIPS32 instruction-fetch stage: owns the PC and drives a req/ready instruction memory.
// It registers {instruction, PC+4, valid} into IF/ID. Define FETCH_STATS_EN to add fetch/bubble counters.
module etapa_busqueda #(
  parameter logic [31:0] PC_RESET = 32'h0000_0000,
  parameter logic [31:0] NOP_WORD = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_target,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_data,
  output logic [31:0] inst_out,
  output logic [31:0] pc4_out,
  output logic        valid_out
`ifdef FETCH_STATS_EN
  ,
  output logic [31:0] stat_fetched,
  output logic [31:0] stat_bubbles
`endif
);

  typedef enum logic [1:0] {FETCH, DROP, HOLD} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] drop_addr_q, drop_addr_d;
  logic [31:0] skid_inst_q, skid_inst_d;
  logic [31:0] skid_pc4_q, skid_pc4_d;
  logic [31:0] inst_q, inst_d;
  logic [31:0] pc4_q, pc4_d;
  logic        valid_q, valid_d;
  logic [31:0] pc_plus4;

  assign pc_plus4  = pc_q + 32'd4;
  assign imem_req  = !reset && (state_q != HOLD);
  // DROP keeps presenting the orphaned address so the handshake stays stable.
  assign imem_addr = (state_q == DROP) ? drop_addr_q : pc_q;
  assign inst_out  = inst_q;
  assign pc4_out   = pc4_q;
  assign valid_out = valid_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= FETCH;
      pc_q        <= PC_RESET;
      drop_addr_q <= PC_RESET;
      skid_inst_q <= NOP_WORD;
      skid_pc4_q  <= 32'd0;
      inst_q      <= NOP_WORD;
      pc4_q       <= 32'd0;
      valid_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      pc_q        <= pc_d;
      drop_addr_q <= drop_addr_d;
      skid_inst_q <= skid_inst_d;
      skid_pc4_q  <= skid_pc4_d;
      inst_q      <= inst_d;
      pc4_q       <= pc4_d;
      valid_q     <= valid_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    pc_d        = pc_q;
    drop_addr_d = drop_addr_q;
    skid_inst_d = skid_inst_q;
    skid_pc4_d  = skid_pc4_q;
    inst_d      = inst_q;
    pc4_d       = pc4_q;
    valid_d     = valid_q;
    if (branch_taken) begin
      pc_d    = branch_target & ~32'd3;
      inst_d  = NOP_WORD;
      valid_d = 1'b0;
      case (state_q)
        FETCH: begin
          if (!imem_ready) begin
            state_d     = DROP;
            drop_addr_d = pc_q;
          end
        end
        DROP:    state_d = imem_ready ? FETCH : DROP;
        default: state_d = FETCH;
      endcase
    end else begin
      case (state_q)
        FETCH: begin
          if (imem_ready) begin
            pc_d = pc_plus4;
            if (stall) begin
              skid_inst_d = imem_data;
              skid_pc4_d  = pc_plus4;
              state_d     = HOLD;
            end else begin
              inst_d  = imem_data;
              pc4_d   = pc_plus4;
              valid_d = 1'b1;
            end
          end else if (!stall) begin
            inst_d  = NOP_WORD;
            valid_d = 1'b0;
          end
        end
        HOLD: begin
          if (!stall) begin
            inst_d  = skid_inst_q;
            pc4_d   = skid_pc4_q;
            valid_d = 1'b1;
            state_d = FETCH;
          end
        end
        DROP: begin
          if (imem_ready) state_d = FETCH;
          if (!stall) begin
            inst_d  = NOP_WORD;
            valid_d = 1'b0;
          end
        end
        default: state_d = FETCH;
      endcase
    end
  end

`ifdef FETCH_STATS_EN
  logic [31:0] fetched_q, bubbles_q;
  logic        load_real, insert_nop;

  assign load_real  = !branch_taken && !stall &&
                      (((state_q == FETCH) && imem_ready) || (state_q == HOLD));
  assign insert_nop = branch_taken ||
                      (!stall && ((state_q == DROP) || ((state_q == FETCH) && !imem_ready)));
  assign stat_fetched = fetched_q;
  assign stat_bubbles = bubbles_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      fetched_q <= 32'd0;
      bubbles_q <= 32'd0;
    end else begin
      if (load_real)  fetched_q <= fetched_q + 32'd1;
      if (insert_nop) bubbles_q <= bubbles_q + 32'd1;
    end
  end
`endif

endmodule
